fetch_decode_pipe: RTL and testbench
====================================

// Module: fetch_decode_pipe
// PURPOSE
//  Parametrised fetch/decode front end with prefetch FIFO, valid/ready decode handshake and branch redirect/flush.
//  Issues sequential PC requests to instruction memory (fixed 1-cycle read latency) and buffers {pc,instr} pairs.
//  Decodes the FIFO head into register indices and a sign-extended immediate for the FD/execute stage.
// PARAMETERS
//  XLEN        64      datapath width of dec_imm
//  ADDR_W      32      PC / instruction address width
//  FIFO_DEPTH  4       prefetch entries, power of 2, >=2
//  RESET_PC    0       PC value loaded on reset
// PORTS
//  clk             in   1       clock, rising edge
//  rst_n           in   1       synchronous reset, active low
//  fetch_en        in   1       allow new imem requests
//  imem_req        out  1       read request this cycle
//  imem_addr       out  ADDR_W  request address, word aligned
//  imem_rvalid     in   1       response valid, exactly 1 cycle after imem_req
//  imem_rdata      in   32      instruction word
//  redirect_valid  in   1       branch/jump taken: flush and restart
//  redirect_pc     in   ADDR_W  new PC; bits[1:0] ignored (forced 0)
//  dec_valid       out  1       decoded instruction available
//  dec_ready       in   1       consumer accepts; transfer = dec_valid & dec_ready
//  dec_pc          out  ADDR_W  PC of head instruction
//  dec_instr       out  32      raw head instruction
//  dec_ra/rb/rw    out  5 each  rs1 / rs2 / rd indices
//  dec_imm         out  XLEN    sign-extended immediate
//  dec_fmt         out  3       format: R,I,S,B,U,J,ILLEGAL (package enum)
// BEHAVIOUR
//  Reset (rst_n=0 at edge): pc=RESET_PC, FIFO empty, inflight=0, drop=0, imem_req=0, dec_valid=0, perf counters=0.
//  Issue: imem_req=fetch_en & !redirect_valid & (count+inflight < FIFO_DEPTH); imem_addr=pc; on issue pc<=pc+4 (wraps mod 2^ADDR_W).
//  Response: when imem_rvalid & inflight & !drop, push {addr_q, imem_rdata}; rvalid with inflight=0 ignored (covers reset mid-fetch).
//  Latency: first request cycle after reset; dec_valid high 2 cycles after first imem_req.
//  Full: no request when count+inflight==FIFO_DEPTH; never overflows. Push and pop same cycle: count unchanged.
//  Empty: dec_valid=0; decoded outputs hold last head (don't care).
//  Redirect: same cycle FIFO cleared, dec_valid forced 0 (no transfer), pc<=redirect_pc&~3, no request; if inflight, drop=1 so next-cycle response discarded.
//  Redirect has priority over push, pop and fetch_en. Back-to-back redirects: last one wins.
//  fetch_en=0: no new requests; in-flight response still pushed; FIFO drains normally.
//  FSM: RUN (normal), FLUSH (1 cycle after redirect, discarding any in-flight response), then RUN; reset -> RUN.
//  Decode (combinational from head): ra=[19:15], rw=[11:7]; rb=[24:20] for R/S/B else 0.
//  Imm: I={[31:20]}, S={[31:25],[11:7]}, B={[31],[7],[30:25],[11:8],0}, U={[31:12],12'b0}, J={[31],[19:12],[20],[30:21],0};
//   all sign-extended from bit 31 to XLEN; R and ILLEGAL give imm=0.
//  Opcode map: 0110011/0111011 R; 0010011/0000011/1100111/0011011 I; 0100011 S; 1100011 B; 0110111/0010111 U; 1101111 J; else ILLEGAL.
// CONFIGURATION
//  FDP_PERF_CNT_EN defined: adds outputs perf_fetched[31:0] (pops), perf_stall[31:0] (dec_valid&!dec_ready cycles),
//   perf_flush[31:0] (redirects); all saturate at 2^32-1, cleared by reset.
//  Not defined: ports and counters absent; datapath identical.
// STRUCTURE
//  Package fdp_pkg: fmt_e enum (R,I,S,B,U,J,ILLEGAL), opcode localparams, imm extraction function.
//  Sub-module fetch_fifo (DEPTH, WIDTH=ADDR_W+32; push/pop/clear/count/full/empty), instantiated once.
//  Top holds PC, inflight/drop flags, FSM, decode, optional perf counters.
// TESTING
//  Reset, fetch_en=1, dec_ready=1, imem returns addr-tagged words -> imem_addr 0,4,8..; dec_pc 0 two cycles after first req.
//  dec_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests then imem_req=0; release -> pcs 0..12 in order, no loss/duplication.
//  redirect to 0x103 while one request inflight -> response dropped, next imem_addr=0x100, next dec_pc=0x100.
//  Head 0xFE010113 (addi sp,sp,-32) -> fmt=I, ra=2, rw=2, rb=0, imm=0xFFFF_FFFF_FFFF_FFE0.
//  Head 0xFE20CEE3 (blt-type B) -> fmt=B, rb=2, imm=-4 sign-extended; pc=0xFFFF_FFFC issue -> next addr 0x0.
//  rst_n low 1 cycle mid-stream with inflight -> dec_valid=0, stale rvalid ignored, restart at RESET_PC; perf counters 0 (FDP_PERF_CNT_EN).

Source files
------------

// File: rtl/fdp_pkg.sv
// Shared types, opcode constants and decode helpers for the fetch/decode front end.
package fdp_pkg;

   typedef enum logic [2:0] {
      FMT_R       = 3'd0,
      FMT_I       = 3'd1,
      FMT_S       = 3'd2,
      FMT_B       = 3'd3,
      FMT_U       = 3'd4,
      FMT_J       = 3'd5,
      FMT_ILLEGAL = 3'd6
   } fmt_e;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_e;

   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_OP_32  = 7'b0111011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   // Map a major opcode onto its instruction format; unknown opcodes are ILLEGAL.
   function automatic fmt_e opcode_fmt(input logic [6:0] opcode);
      fmt_e fmt;
      case (opcode)
         OP_OP, OP_OP_32:                      fmt = FMT_R;
         OP_IMM, OP_LOAD, OP_JALR, OP_IMM_32:  fmt = FMT_I;
         OP_STORE:                             fmt = FMT_S;
         OP_BRANCH:                            fmt = FMT_B;
         OP_LUI, OP_AUIPC:                     fmt = FMT_U;
         OP_JAL:                               fmt = FMT_J;
         default:                              fmt = FMT_ILLEGAL;
      endcase
      return fmt;
   endfunction

   // Reassemble the immediate field for a format, sign-extended from bit 31 to 32 bits.
   function automatic logic [31:0] imm_extract(input logic [31:0] instr, input fmt_e fmt);
      logic [31:0] imm;
      case (fmt)
         FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
         FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         FMT_U:   imm = {instr[31:12], 12'b0};
         FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm = 32'd0;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instr} pairs; clear empties it in one cycle and beats push/pop.
module fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign do_pop   = pop & !empty & !clear;
   assign do_push  = push & (!full | do_pop) & !clear;
   assign pop_data = mem[rd_ptr];

   // Storage array; pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping; simultaneous push and pop leave count unchanged.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fetch_decode_pipe.sv
// Fetch/decode front end: sequential PC issue, prefetch FIFO, head decode and branch redirect.
// Optional performance counters are built when the macro FDP_PERF_CNT_EN is defined.
module fetch_decode_pipe
   import fdp_pkg::*;
#(
   parameter int                XLEN       = 64,
   parameter int                ADDR_W     = 32,
   parameter int                FIFO_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fetch_en,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_rvalid,
   input  logic [31:0]       imem_rdata,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              dec_valid,
   input  logic              dec_ready,
   output logic [ADDR_W-1:0] dec_pc,
   output logic [31:0]       dec_instr,
   output logic [4:0]        dec_ra,
   output logic [4:0]        dec_rb,
   output logic [4:0]        dec_rw,
   output logic [XLEN-1:0]   dec_imm,
   output logic [2:0]        dec_fmt
`ifdef FDP_PERF_CNT_EN
   ,
   output logic [31:0]       perf_fetched,
   output logic [31:0]       perf_stall,
   output logic [31:0]       perf_flush
`endif
);

   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int ENTRY_W = ADDR_W + 32;

   logic [ADDR_W-1:0]  pc;
   logic [ADDR_W-1:0]  addr_q;
   logic               inflight;
   logic               drop;
   state_e             state;

   logic               issue;
   logic [CNT_W:0]     occupancy;
   logic               fifo_push;
   logic               fifo_pop;
   logic [ENTRY_W-1:0] fifo_head;
   logic [CNT_W-1:0]   fifo_count;
   logic               fifo_full;
   logic               fifo_empty;

   logic [31:0]        head_instr;
   fmt_e               head_fmt;
   logic [31:0]        head_imm32;

   // Requests in flight reserve a FIFO slot so a returning word always has room.
   assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};
   assign issue     = rst_n & fetch_en & !redirect_valid & (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
   assign imem_req  = issue;
   assign imem_addr = pc;

   assign fifo_push = imem_rvalid & inflight & !drop & !redirect_valid & !fifo_full;
   assign dec_valid = !fifo_empty & !redirect_valid;
   assign fifo_pop  = dec_valid & dec_ready;

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (redirect_valid),
      .push      (fifo_push),
      .push_data ({addr_q, imem_rdata}),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign head_instr = fifo_head[31:0];
   assign head_fmt   = opcode_fmt(head_instr[6:0]);
   assign head_imm32 = imm_extract(head_instr, head_fmt);

   assign dec_pc    = fifo_head[ENTRY_W-1:32];
   assign dec_instr = head_instr;
   assign dec_ra    = head_instr[19:15];
   assign dec_rw    = head_instr[11:7];
   assign dec_rb    = (head_fmt == FMT_R || head_fmt == FMT_S || head_fmt == FMT_B) ? head_instr[24:20] : 5'd0;
   assign dec_imm   = XLEN'($signed(head_imm32));
   assign dec_fmt   = head_fmt;

   // PC sequencing and in-flight tracking; a redirect overrides sequential issue and marks any outstanding word stale.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc       <= RESET_PC;
         addr_q   <= '0;
         inflight <= 1'b0;
         drop     <= 1'b0;
      end else begin
         inflight <= issue;
         drop     <= redirect_valid & inflight;
         if (issue) begin
            addr_q <= pc;
         end
         if (redirect_valid) begin
            pc <= redirect_pc & ~ADDR_W'(3);
         end else if (issue) begin
            pc <= pc + ADDR_W'(4);
         end
      end
   end

   // Flush FSM: one FLUSH cycle follows the last redirect of a burst, then back to RUN.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_RUN;
      end else begin
         case (state)
            ST_RUN:   state <= redirect_valid ? ST_FLUSH : ST_RUN;
            ST_FLUSH: state <= redirect_valid ? ST_FLUSH : ST_RUN;
            default:  state <= ST_RUN;
         endcase
      end
   end

`ifdef FDP_PERF_CNT_EN
   // Saturating event counters for delivered instructions, back-pressure cycles and redirects.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_fetched <= '0;
         perf_stall   <= '0;
         perf_flush   <= '0;
      end else begin
         if (fifo_pop && perf_fetched != '1) begin
            perf_fetched <= perf_fetched + 32'd1;
         end
         if (dec_valid && !dec_ready && perf_stall != '1) begin
            perf_stall <= perf_stall + 32'd1;
         end
         if (redirect_valid && perf_flush != '1) begin
            perf_flush <= perf_flush + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_decode_pipe.sv
// Directed bench for fetch_decode_pipe with a one-cycle instruction memory model.
// Words read back equal their address except at 0x200/0x204, which hold real instructions.
module tb_fetch_decode_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_en;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        dec_valid;
   logic        dec_ready;
   logic [31:0] dec_pc;
   logic [31:0] dec_instr;
   logic [4:0]  dec_ra;
   logic [4:0]  dec_rb;
   logic [4:0]  dec_rw;
   logic [63:0] dec_imm;
   logic [2:0]  dec_fmt;
`ifdef FDP_PERF_CNT_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_stall;
   logic [31:0] perf_flush;
`endif

   logic        rvalid_q = 1'b0;
   logic [31:0] rdata_q = 32'd0;
   logic        stale_inject = 1'b0;

   int checks = 0;
   int errors = 0;

   fetch_decode_pipe #(
      .XLEN       (64),
      .ADDR_W     (32),
      .FIFO_DEPTH (4),
      .RESET_PC   (32'h0)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .fetch_en       (fetch_en),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .dec_valid      (dec_valid),
      .dec_ready      (dec_ready),
      .dec_pc         (dec_pc),
      .dec_instr      (dec_instr),
      .dec_ra         (dec_ra),
      .dec_rb         (dec_rb),
      .dec_rw         (dec_rw),
      .dec_imm        (dec_imm),
      .dec_fmt        (dec_fmt)
`ifdef FDP_PERF_CNT_EN
      ,
      .perf_fetched   (perf_fetched),
      .perf_stall     (perf_stall),
      .perf_flush     (perf_flush)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0200: return 32'hFE01_0113;
         32'h0000_0204: return 32'hFE20_CEE3;
         default:       return a;
      endcase
   endfunction

   // Memory answers every request exactly one cycle later; stale_inject forces a spurious response.
   always @(posedge clk) begin
      rvalid_q <= imem_req;
      rdata_q  <= mem_word(imem_addr);
   end

   assign imem_rvalid = rvalid_q | stale_inject;
   assign imem_rdata  = rdata_q;

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic apply_stimulus(input logic rst_v, input logic fe, input logic rdy,
                                 input logic rv, input logic [31:0] rpc);
      rst_n          = rst_v;
      fetch_en       = fe;
      dec_ready      = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      #1;
   endtask

   task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      $display("[TB] start");
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      check_output("reset_req", 64'(imem_req), 64'd0);
      check_output("reset_valid", 64'(dec_valid), 64'd0);
      tick();

      // Out of reset with fetching disabled: nothing requested, PC at reset value.
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      check_output("idle_req", 64'(imem_req), 64'd0);
      check_output("idle_addr", 64'(imem_addr), 64'h0);
      check_output("idle_valid", 64'(dec_valid), 64'd0);
`ifdef FDP_PERF_CNT_EN
      check_output("perf_reset_fetched", 64'(perf_fetched), 64'd0);
      check_output("perf_reset_stall", 64'(perf_stall), 64'd0);
      check_output("perf_reset_flush", 64'(perf_flush), 64'd0);
`endif

      // Streaming: addresses step by 4, head shows up two cycles after its request.
      apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      for (int k = 0; k < 6; k++) begin
         check_output("stream_req", 64'(imem_req), 64'd1);
         check_output("stream_addr", 64'(imem_addr), 64'(4 * k));
         check_output("stream_valid", 64'(dec_valid), 64'(k >= 2));
         if (k >= 2) begin
            check_output("stream_pc", 64'(dec_pc), 64'(4 * (k - 2)));
            check_output("stream_instr", 64'(dec_instr), 64'(4 * (k - 2)));
         end
         if (k < 5) tick();
      end

      // Reset pulse while a request is in flight; a spurious rvalid right after is ignored.
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      check_output("rst_gate_req", 64'(imem_req), 64'd0);
      tick();
      stale_inject = 1'b1;
      apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
`ifdef FDP_PERF_CNT_EN
      check_output("perf_mid_rst_fetched", 64'(perf_fetched), 64'd0);
      check_output("perf_mid_rst_stall", 64'(perf_stall), 64'd0);
      check_output("perf_mid_rst_flush", 64'(perf_flush), 64'd0);
`endif

      // Back-pressure for ten cycles: exactly FIFO_DEPTH requests, head held at PC 0.
      for (int i = 0; i < 10; i++) begin
         check_output("stall_req", 64'(imem_req), 64'(i < 4));
         check_output("stall_valid", 64'(dec_valid), 64'(i >= 2));
         if (i < 4) check_output("stall_addr", 64'(imem_addr), 64'(4 * i));
         if (i >= 2) check_output("stall_pc", 64'(dec_pc), 64'h0);
         tick();
         stale_inject = 1'b0;
         #1;
      end
`ifdef FDP_PERF_CNT_EN
      check_output("perf_stall_cnt", 64'(perf_stall), 64'd8);
      check_output("perf_stall_fetched", 64'(perf_fetched), 64'd0);
`endif

      // Release: buffered PCs drain in order and fetching resumes where it stopped.
      apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      for (int j = 0; j < 5; j++) begin
         check_output("drain_valid", 64'(dec_valid), 64'd1);
         check_output("drain_pc", 64'(dec_pc), 64'(4 * j));
         check_output("drain_instr", 64'(dec_instr), 64'(4 * j));
         check_output("drain_req", 64'(imem_req), 64'(j >= 1));
         if (j >= 1) check_output("drain_addr", 64'(imem_addr), 64'(12 + 4 * j));
         if (j < 4) tick();
      end

      // Redirect to 0x103 with a word in flight: no transfer, no request, stale word lost.
      apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h103);
      check_output("redir_valid", 64'(dec_valid), 64'd0);
      check_output("redir_req", 64'(imem_req), 64'd0);
      tick();
      apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      check_output("redir_addr0", 64'(imem_addr), 64'h100);
      check_output("redir_req0", 64'(imem_req), 64'd1);
      check_output("redir_flush_valid", 64'(dec_valid), 64'd0);
      tick();
      check_output("redir_addr1", 64'(imem_addr), 64'h104);
      check_output("redir_empty_valid", 64'(dec_valid), 64'd0);
      tick();
      check_output("redir_head_valid", 64'(dec_valid), 64'd1);
      check_output("redir_head_pc", 64'(dec_pc), 64'h100);

      // Two redirects back to back: the second target wins.
      apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h203);
      check_output("b2b_valid", 64'(dec_valid), 64'd0);
      tick();
      apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h200);
      check_output("b2b_req", 64'(imem_req), 64'd0);
      tick();
      apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      check_output("b2b_addr", 64'(imem_addr), 64'h200);
      check_output("b2b_req_after", 64'(imem_req), 64'd1);
      tick();
      check_output("b2b_addr_next", 64'(imem_addr), 64'h204);
      tick();

      // addi sp,sp,-32 at the head.
      check_output("i_pc", 64'(dec_pc), 64'h200);
      check_output("i_instr", 64'(dec_instr), 64'hFE01_0113);
      check_output("i_fmt", 64'(dec_fmt), 64'd1);
      check_output("i_ra", 64'(dec_ra), 64'd2);
      check_output("i_rw", 64'(dec_rw), 64'd2);
      check_output("i_rb", 64'(dec_rb), 64'd0);
      check_output("i_imm", dec_imm, 64'hFFFF_FFFF_FFFF_FFE0);
      tick();

      // blt x1,x2,-4 at the head.
      check_output("b_pc", 64'(dec_pc), 64'h204);
      check_output("b_fmt", 64'(dec_fmt), 64'd3);
      check_output("b_ra", 64'(dec_ra), 64'd1);
      check_output("b_rb", 64'(dec_rb), 64'd2);
      check_output("b_imm", dec_imm, 64'hFFFF_FFFF_FFFF_FFFC);
      tick();

      // Address-tagged word 0x208 has opcode 0001000, which is not a known format.
      check_output("ill_pc", 64'(dec_pc), 64'h208);
      check_output("ill_fmt", 64'(dec_fmt), 64'd6);
      check_output("ill_imm", dec_imm, 64'h0);
      check_output("ill_rb", 64'(dec_rb), 64'd0);

      // Redirect with low bits set to the top word: address is aligned and wraps to 0.
      apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
      tick();
      apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      check_output("wrap_addr_top", 64'(imem_addr), 64'hFFFF_FFFC);
      check_output("wrap_req_top", 64'(imem_req), 64'd1);
      tick();
      check_output("wrap_addr_zero", 64'(imem_addr), 64'h0);

      // Fetch disabled: no new request, but the word already in flight still arrives.
      apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      check_output("fe_off_req", 64'(imem_req), 64'd0);
      tick();
      check_output("fe_off_valid", 64'(dec_valid), 64'd1);
      check_output("fe_off_pc", 64'(dec_pc), 64'hFFFF_FFFC);
      check_output("fe_off_req2", 64'(imem_req), 64'd0);
      tick();
      check_output("fe_off_drained", 64'(dec_valid), 64'd0);
      check_output("fe_off_req3", 64'(imem_req), 64'd0);
`ifdef FDP_PERF_CNT_EN
      check_output("perf_end_fetched", 64'(perf_fetched), 64'd7);
      check_output("perf_end_stall", 64'(perf_stall), 64'd8);
      check_output("perf_end_flush", 64'(perf_flush), 64'd4);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
